usb_tx_encode: RTL and testbench
================================

Name: usb_tx_encode

Overview:
USB full-speed transmit line encoder, the transmit-side counterpart of the receive-path NRZI decoder. Accepts packet bytes over a valid/ready stream, prepends SYNC and serializes LSB-first. Inserts a stuffed zero after every six consecutive ones, NRZI-encodes the bitstream onto d_plus/d_minus, and terminates the packet with EOP. Sits between the packet/CRC builder and the USB pad driver.

Parameters:
SYNC_PATTERN, 8'h80, SYNC byte sent LSB-first: seven 0s then a 1.
STUFF_LEN, 6, number of consecutive ones that forces a stuffed 0.
EOP_SE0_BITS, 2, number of bit times SE0 is held during EOP.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
bit_tick  in  1  one-cycle strobe per USB bit time; all line activity advances only on a tick
tx_data  in  8  packet byte
tx_valid  in  1  tx_data/tx_last valid
tx_last  in  1  marks the final byte of the packet
tx_ready  out  1  block accepts a byte this cycle (transfer = valid & ready)
d_plus  out  1  encoded D+ line
d_minus  out  1  encoded D- line
tx_oe  out  1  pad output enable
busy  out  1  packet in progress (not IDLE)
err_underrun  out  1  one-cycle pulse when the byte stream starves mid-packet

Behaviour:
- Reset (rst sampled high at a clk edge) values: d_plus=1, d_minus=0 (J), tx_oe=0, busy=0, tx_ready=0, err_underrun=0.
  - Reset also sets state IDLE, clears the holding and shift registers, and sets ones_cnt=0.
  - Reset mid-packet aborts immediately; no EOP is sent.
- tx_ready is registered. It rises the cycle after reset deasserts.
- Datapath: holding register plus shift register (double buffer).
  - tx_ready=1 while the holding register is empty and tx_last has not yet been accepted for the current packet.
  - After tx_last is accepted, tx_ready stays 0 until return to IDLE.
- States: IDLE, SYNC, DATA, EOP_SE0, EOP_J.
  - IDLE: line J, tx_oe=0. A transfer loads the holding register.
    - On the next bit_tick: state goes to SYNC, tx_oe=1, busy=1, and the first SYNC bit is driven.
  - SYNC: sends 8 SYNC bits. On the tick after the eighth bit, the holding register moves to the shift register and state goes to DATA.
  - DATA: one bit per tick, LSB first, bit counter 0..7. When bit 7 completes:
    - holding full: reload the shift register, continue with no gap bit.
    - last byte was tx_last: go to EOP_SE0.
    - holding empty and tx_last not seen: pulse err_underrun for 1 clk, go to EOP_SE0 (truncated packet).
  - EOP_SE0: d_plus=d_minus=0 for EOP_SE0_BITS ticks. Does not toggle NRZI state.
  - EOP_J: J for 1 tick. At the following tick: tx_oe=0, busy=0, state IDLE. NRZI reference resets to J.
- NRZI: a bit 0 toggles the line (J↔K), a bit 1 holds it. J = (1,0), K = (0,1). The line starts each packet at J.
- Bit stuffing:
  - ones_cnt counts consecutive transmitted 1s, including SYNC's final 1. Any 0 (data or stuffed) clears it.
  - When ones_cnt reaches STUFF_LEN, the next tick sends a stuffed 0 (line toggles, ones_cnt=0) and the pending data bit is held.
  - A stuff owed after the last data bit is sent before EOP_SE0.
- tx_ready is unaffected by stuff bits, except that the shift register is not reloaded until its 8 data bits are sent.
- Ticks are one clk wide. Line outputs update only at the clk edge where bit_tick=1. bit_tick gaps freeze all state.
- A transfer and a bit_tick in the same cycle are both honoured. The byte may be loaded into the shift register on that same tick if it is needed.

Decomposition:
- Package usb_tx_pkg:
  - state enum tx_state_t
  - line-state constants LINE_J, LINE_K, LINE_SE0 (2-bit {dp,dm})
  - SYNC and stuff-length defaults
- One sub-module, usb_bit_stuff_nrzi. It takes a raw bit, a tick and an se0 request, owns ones_cnt and the NRZI line register, and returns a stall indication while it inserts a stuffed 0.
- The top module holds the FSM, buffers and handshake.

Test Plan:
1. Send 0x00 with tx_last → per-tick line K,J,K,J,K,J,K,K (SYNC), then J,K,J,K,J,K,J,K, then SE0,SE0,J. tx_oe is 1 for 19 ticks and tx_ready returns to 1 in IDLE.
2. Send 0xFF with tx_last → after SYNC (line K), 5 ticks hold K, then a stuffed toggle to J, then 3 ticks hold J, then EOP. The byte spans 9 bit times.
3. Send 0x3F then 0x01 back-to-back, tx_last on the second → no gap between bytes. There is one stuff bit after the 5th data bit of 0x3F, and tx_ready=0 after the second transfer until IDLE.
4. Send 0x55 without tx_last, then drop tx_valid → err_underrun pulses exactly 1 clk after bit 7 completes, then SE0,SE0,J, tx_oe=0.
5. Assert rst during the DATA bit 3 tick → on the next clk: d_plus=1, d_minus=0, tx_oe=0, busy=0, tx_ready=0. tx_ready=1 one cycle after rst deasserts; a new packet encodes from J correctly.
6. Hold bit_tick low for 5 clks mid-DATA with tx_valid toggling → line and bit counter stay frozen, at most one byte is accepted into holding, and the stream resumes intact.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit encoder.
// Line states are packed as {d_plus, d_minus}.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0]  SYNC_PATTERN_DEF = 8'h80;
  localparam int unsigned STUFF_LEN_DEF    = 6;
  localparam int unsigned EOP_SE0_BITS_DEF = 2;

  // NRZI transition between the two differential data states
  function automatic logic [1:0] line_toggle(input logic [1:0] line);
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_bit_stuff_nrzi.sv
// Bit stuffer and NRZI line driver: owns the run-of-ones counter and the
// registered line state; stalls the bit source while a stuffed 0 goes out.
module usb_bit_stuff_nrzi
  import usb_tx_pkg::*;
#(
  parameter int unsigned STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_bit,
  input  logic       i_se0,
  input  logic       i_force_j,
  output logic [1:0] o_line,
  output logic       o_stall_c
);

  localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);

  logic [ONES_W-1:0] r_ones;
  logic [1:0]        r_line;

  assign o_stall_c = (r_ones == ONES_W'(STUFF_LEN));
  assign o_line    = r_line;

  // Priority: end-of-packet J, owed stuff bit, SE0, then the data bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line <= LINE_J;
      r_ones <= '0;
    end else if (i_tick) begin
      if (i_force_j) begin
        r_line <= LINE_J;
        r_ones <= '0;
      end else if (o_stall_c) begin
        r_line <= line_toggle(r_line);
        r_ones <= '0;
      end else if (i_se0) begin
        r_line <= LINE_SE0;
        r_ones <= '0;
      end else if (i_bit) begin
        r_ones <= r_ones + ONES_W'(1);
      end else begin
        r_line <= line_toggle(r_line);
        r_ones <= '0;
      end
    end
  end

endmodule

// File: rtl/usb_tx_encode.sv
// USB full-speed transmit encoder: byte stream in, SYNC + stuffed NRZI data
// + EOP out on d_plus/d_minus. Holding + shift register double buffer.
module usb_tx_encode
  import usb_tx_pkg::*;
#(
  parameter logic [7:0]  SYNC_PATTERN = SYNC_PATTERN_DEF,
  parameter int unsigned STUFF_LEN    = STUFF_LEN_DEF,
  parameter int unsigned EOP_SE0_BITS = EOP_SE0_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_oe,
  output logic       busy,
  output logic       err_underrun
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  tx_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [BYTE_W-1:0] r_hold, w_hold_nxt;
  logic [BYTE_W-1:0] r_shift, w_shift_nxt;
  logic              r_hold_full, w_hold_full_nxt;
  logic              r_hold_last, w_hold_last_nxt;
  logic              r_shift_full, w_shift_full_nxt;
  logic              r_shift_last, w_shift_last_nxt;
  logic              r_last_seen, w_last_seen_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_err, w_err_nxt;
  logic              r_active, w_active_nxt;

  logic              w_xfer;
  logic              w_hold_avail;
  logic [BYTE_W-1:0] w_hold_src;
  logic              w_hold_src_last;
  logic [BYTE_W-1:0] w_byte;
  logic              w_stall;
  logic              w_adv;
  logic              w_st_tick;
  logic              w_raw_bit;
  logic              w_se0;
  logic              w_force_j;
  logic [1:0]        w_line;

  // A byte arriving this cycle can bypass the holding register
  assign w_xfer          = tx_valid & r_ready;
  assign w_hold_avail    = r_hold_full | w_xfer;
  assign w_hold_src      = r_hold_full ? r_hold : tx_data;
  assign w_hold_src_last = r_hold_full ? r_hold_last : tx_last;
  assign w_byte          = r_shift_full ? r_shift : w_hold_src;
  assign w_adv           = bit_tick & ~w_stall;

  usb_bit_stuff_nrzi #(
    .STUFF_LEN (STUFF_LEN)
  ) u_stuff (
    .clk       (clk),
    .rst       (rst),
    .i_tick    (w_st_tick),
    .i_bit     (w_raw_bit),
    .i_se0     (w_se0),
    .i_force_j (w_force_j),
    .o_line    (w_line),
    .o_stall_c (w_stall)
  );

  assign {d_plus, d_minus} = w_line;
  assign tx_ready          = r_ready;
  assign tx_oe             = r_active;
  assign busy              = r_active;
  assign err_underrun      = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_shift      <= '0;
      r_hold_full  <= 1'b0;
      r_hold_last  <= 1'b0;
      r_shift_full <= 1'b0;
      r_shift_last <= 1'b0;
      r_last_seen  <= 1'b0;
      r_ready      <= 1'b0;
      r_err        <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hold       <= w_hold_nxt;
      r_shift      <= w_shift_nxt;
      r_hold_full  <= w_hold_full_nxt;
      r_hold_last  <= w_hold_last_nxt;
      r_shift_full <= w_shift_full_nxt;
      r_shift_last <= w_shift_last_nxt;
      r_last_seen  <= w_last_seen_nxt;
      r_ready      <= w_ready_nxt;
      r_err        <= w_err_nxt;
      r_active     <= w_active_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_hold_nxt       = r_hold;
    w_hold_full_nxt  = r_hold_full;
    w_hold_last_nxt  = r_hold_last;
    w_shift_nxt      = r_shift;
    w_shift_full_nxt = r_shift_full;
    w_shift_last_nxt = r_shift_last;
    w_last_seen_nxt  = r_last_seen;
    w_err_nxt        = 1'b0;
    w_active_nxt     = r_active;
    w_st_tick        = 1'b0;
    w_raw_bit        = 1'b1;
    w_se0            = 1'b0;
    w_force_j        = 1'b0;

    if (w_xfer) begin
      w_hold_nxt      = tx_data;
      w_hold_full_nxt = 1'b1;
      w_hold_last_nxt = tx_last;
      if (tx_last) begin
        w_last_seen_nxt = 1'b1;
      end
    end

    unique case (r_state)
      ST_IDLE: begin
        if (bit_tick && w_hold_avail) begin
          w_st_tick        = 1'b1;
          w_raw_bit        = SYNC_PATTERN[0];
          w_state_nxt      = ST_SYNC;
          w_cnt_nxt        = CNT_W'(1);
          w_shift_full_nxt = 1'b0;
          w_active_nxt     = 1'b1;
        end
      end
      ST_SYNC: begin
        if (bit_tick) begin
          w_st_tick = 1'b1;
          w_raw_bit = SYNC_PATTERN[r_cnt[2:0]];
          if (w_adv) begin
            if (r_cnt == CNT_W'(7)) begin
              w_state_nxt = ST_DATA;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          w_st_tick = 1'b1;
          w_raw_bit = w_byte[r_cnt[2:0]];
          if (w_adv) begin
            // First data bit after SYNC pulls the byte out of holding
            if (!r_shift_full) begin
              w_shift_nxt      = w_hold_src;
              w_shift_last_nxt = w_hold_src_last;
              w_shift_full_nxt = 1'b1;
              w_hold_full_nxt  = 1'b0;
              w_cnt_nxt        = r_cnt + CNT_W'(1);
            end else if (r_cnt == CNT_W'(7)) begin
              w_cnt_nxt = '0;
              if (w_hold_avail) begin
                w_shift_nxt      = w_hold_src;
                w_shift_last_nxt = w_hold_src_last;
                w_hold_full_nxt  = 1'b0;
              end else begin
                w_err_nxt        = ~r_shift_last;
                w_shift_full_nxt = 1'b0;
                w_state_nxt      = ST_EOP_SE0;
              end
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
      end
      ST_EOP_SE0: begin
        if (bit_tick) begin
          w_st_tick = 1'b1;
          w_se0     = 1'b1;
          if (w_adv) begin
            if (r_cnt == CNT_W'(EOP_SE0_BITS - 1)) begin
              w_state_nxt = ST_EOP_J;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
      end
      ST_EOP_J: begin
        if (bit_tick) begin
          w_st_tick = 1'b1;
          w_force_j = 1'b1;
          if (r_cnt == '0) begin
            w_cnt_nxt = CNT_W'(1);
          end else begin
            w_state_nxt     = ST_IDLE;
            w_cnt_nxt       = '0;
            w_active_nxt    = 1'b0;
            w_last_seen_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Bytes arriving during EOP would belong to the next packet; hold them off
    w_ready_nxt = ~w_hold_full_nxt & ~w_last_seen_nxt &
                  (w_state_nxt != ST_EOP_SE0) & (w_state_nxt != ST_EOP_J);
  end

endmodule

// File: tb/tb_usb_tx_encode.sv
// Directed bench for usb_tx_encode: per-tick line checks against hand-written
// J/K/SE0 sequences ('0' = SE0), plus handshake, underrun, reset and freeze.
module tb_usb_tx_encode;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       d_plus;
  logic       d_minus;
  logic       tx_oe;
  logic       busy;
  logic       err_underrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] feed0;
  logic [7:0] feed1;
  int         feed_n;
  int         feed_idx;
  logic       feed_last;

  usb_tx_encode dut (
    .clk          (clk),
    .rst          (rst),
    .bit_tick     (bit_tick),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .d_plus       (d_plus),
    .d_minus      (d_minus),
    .tx_oe        (tx_oe),
    .busy         (busy),
    .err_underrun (err_underrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ch2line(input byte c);
    if (c == "J") return 2'b10;
    if (c == "K") return 2'b01;
    return 2'b00;
  endfunction

  // One clk: present the feed byte (if any), optional tick, track transfers
  task automatic step(input logic tk, input logic vmask);
    logic rdy;
    tx_valid = vmask && (feed_idx < feed_n);
    tx_data  = (feed_idx == 0) ? feed0 : feed1;
    tx_last  = feed_last && (feed_idx == feed_n - 1);
    bit_tick = tk;
    rdy      = tx_ready;
    @(posedge clk);
    #1;
    if (tx_valid && rdy) feed_idx++;
    bit_tick = 1'b0;
  endtask

  task automatic run_pkt(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input int n, input logic last, input string exp,
                         input int frz_at, input int exp_err_tick);
    int   tn;
    int   err_cnt;
    int   err_tick;
    int   rdy_viol;
    int   idx0;
    int   frz;
    logic tk;
    logic [1:0] held;
    bit   done;
    feed0 = b0; feed1 = b1; feed_n = n; feed_idx = 0; feed_last = last;
    tn = 0; err_cnt = 0; err_tick = -1; rdy_viol = 0; done = 0; frz = frz_at;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      tk = cyc[0];
      if (tk && tn == frz) begin
        held = {d_plus, d_minus};
        idx0 = feed_idx;
        for (int f = 0; f < 5; f++) step(1'b0, f[0] == 1'b0);
        check_eq({tag, "_frz_line"}, 32'({d_plus, d_minus}), 32'(held));
        check_eq({tag, "_frz_accept"}, 32'((feed_idx - idx0) <= 1), 32'(1));
        frz = -1;
      end
      step(tk, 1'b1);
      if (tk && (tx_oe || tn > 0)) begin
        if (tn < exp.len()) begin
          check_eq($sformatf("%s_line%0d", tag, tn), 32'({d_plus, d_minus}), 32'(ch2line(exp[tn])));
          check_eq($sformatf("%s_oe%0d", tag, tn), 32'(tx_oe), 32'(1));
        end else begin
          check_eq({tag, "_oe_end"}, 32'(tx_oe), 32'(0));
          check_eq({tag, "_busy_end"}, 32'(busy), 32'(0));
          check_eq({tag, "_line_end"}, 32'({d_plus, d_minus}), 32'(2'b10));
          done = 1;
        end
        tn++;
      end
      if (err_underrun) begin
        err_cnt++;
        err_tick = tn;
      end
      if (last && feed_idx == n && tx_ready && busy) rdy_viol++;
    end
    check_eq({tag, "_done"}, 32'(done), 32'(1));
    check_eq({tag, "_err_cnt"}, 32'(err_cnt), 32'((exp_err_tick >= 0) ? 1 : 0));
    check_eq({tag, "_err_tick"}, 32'(err_tick), 32'(exp_err_tick));
    check_eq({tag, "_rdy_after_last"}, 32'(rdy_viol), 32'(0));
    check_eq({tag, "_accepted"}, 32'(feed_idx), 32'(n));
    check_eq({tag, "_ready_idle"}, 32'(tx_ready), 32'(1));
  endtask

  initial begin
    int   tn;
    logic tk;
    rst = 1'b1; bit_tick = 1'b0; tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
    feed0 = 8'h00; feed1 = 8'h00; feed_n = 0; feed_idx = 0; feed_last = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("rst_line", 32'({d_plus, d_minus}), 32'(2'b10));
    check_eq("rst_oe", 32'(tx_oe), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_ready", 32'(tx_ready), 32'(0));
    check_eq("rst_err", 32'(err_underrun), 32'(0));
    rst = 1'b0;
    step(1'b0, 1'b0);
    check_eq("ready_after_rst", 32'(tx_ready), 32'(1));

    run_pkt("p00", 8'h00, 8'h00, 1, 1'b1, "KJKJKJKKJKJKJKJK00J", -1, -1);
    run_pkt("pFF", 8'hFF, 8'h00, 1, 1'b1, "KJKJKJKKKKKKKJJJJ00J", -1, -1);
    run_pkt("p3F01", 8'h3F, 8'h01, 2, 1'b1, "KJKJKJKKKKKKKJJKJJKJKJKJK00J", -1, -1);
    run_pkt("p55u", 8'h55, 8'h00, 1, 1'b0, "KJKJKJKKKJJKKJJK00J", -1, 16);

    // Reset on the tick that would send data bit 3
    feed0 = 8'h00; feed_n = 1; feed_idx = 0; feed_last = 1'b1; tn = 0;
    for (int cyc = 0; cyc < 100 && tn < 11; cyc++) begin
      tk = cyc[0];
      step(tk, 1'b1);
      if (tk && (tx_oe || tn > 0)) tn++;
    end
    check_eq("rst_mid_reach", 32'(tn), 32'(11));
    check_eq("rst_mid_busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    check_eq("rst_mid_line", 32'({d_plus, d_minus}), 32'(2'b10));
    check_eq("rst_mid_oe", 32'(tx_oe), 32'(0));
    check_eq("rst_mid_busy", 32'(busy), 32'(0));
    check_eq("rst_mid_ready", 32'(tx_ready), 32'(0));
    step(1'b1, 1'b0);
    check_eq("rst_mid_ready_rise", 32'(tx_ready), 32'(1));
    check_eq("rst_mid_no_eop", 32'({tx_oe, d_plus, d_minus}), 32'(3'b010));

    run_pkt("p00b", 8'h00, 8'h00, 1, 1'b1, "KJKJKJKKJKJKJKJK00J", -1, -1);
    run_pkt("pfrz", 8'h3F, 8'h01, 2, 1'b1, "KJKJKJKKKKKKKJJKJJKJKJKJK00J", 10, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
